// File: rtl/unsigned_nxn_approx_mul_pipe.sv
// Pipelined unsigned NxN multiplier with a per-transaction exact/approximate mode.
// The product is formed combinationally into stage 0; later stages only delay it.
module unsigned_nxn_approx_mul_pipe #(
  parameter int N      = 8,
  parameter int K      = 4,
  parameter int T      = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic             approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   z,
  output logic             approx_o,
  output logic [CNT_W-1:0] approx_cnt
);

  localparam int W = 2 * N;

  logic             adv;
  logic [N-1:0]     x_hi;
  logic [W-1:0]     exact_prod;
  logic [W-1:0]     hi_prod;
  logic [W-1:0]     lo_bits;
  logic [W-1:0]     prod;

  logic [STAGES-1:0]        valid_reg;
  logic [STAGES-1:0]        ap_reg;
  logic [STAGES-1:0][W-1:0] z_reg;
  logic [CNT_W-1:0]         cnt_reg;

  // Upper N-K bits of x, kept in place so y*x_hi == (y*x[N-1:K]) << K.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_xhi
      if (gi >= K) begin : g_keep
        assign x_hi[gi] = x[gi];
      end else begin : g_drop
        assign x_hi[gi] = 1'b0;
      end
    end
  endgenerate

  assign exact_prod = W'(y) * W'(x);
  assign hi_prod    = W'(y) * W'(x_hi);

  // Column c of the low-row approximation: OR of every low-row partial-product
  // bit landing in that column, discarded below column T.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_col
      logic [N-1:0] terms;
      for (genvar gj = 0; gj < N; gj++) begin : g_row
        if (gj < K && gi - gj >= 0 && gi - gj < N) begin : g_term
          assign terms[gj] = x[gj] & y[gi-gj];
        end else begin : g_none
          assign terms[gj] = 1'b0;
        end
      end
      if (gi >= T) begin : g_kept
        assign lo_bits[gi] = |terms;
      end else begin : g_cut
        assign lo_bits[gi] = 1'b0;
      end
    end
  endgenerate

  assign prod = approx ? (hi_prod + lo_bits) : exact_prod;

  // One global stall: the whole pipe advances only when the tail can move.
  assign adv      = !out_valid || out_ready;
  assign in_ready = rst || adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg[0] <= 1'b0;
      ap_reg[0]    <= 1'b0;
      z_reg[0]     <= '0;
    end else if (adv) begin
      valid_reg[0] <= in_valid;
      ap_reg[0]    <= approx;
      z_reg[0]     <= prod;
    end
  end

  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          ap_reg[gi]    <= 1'b0;
          z_reg[gi]     <= '0;
        end else if (adv) begin
          valid_reg[gi] <= valid_reg[gi-1];
          ap_reg[gi]    <= ap_reg[gi-1];
          z_reg[gi]     <= z_reg[gi-1];
        end
      end
    end
  endgenerate

  // Counts approximate requests at acceptance and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (in_valid && adv && approx && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign out_valid  = valid_reg[STAGES-1];
  assign approx_o   = ap_reg[STAGES-1];
  assign z          = z_reg[STAGES-1];
  assign approx_cnt = cnt_reg;

endmodule

// File: tb/tb_unsigned_nxn_approx_mul_pipe.sv
// Drives several multiplier configurations in lockstep from one stimulus stream
// and checks every output against an arithmetic reference model and scoreboard.
module tb_unsigned_nxn_approx_mul_pipe;

  localparam int NI = 8;

  function automatic int cfg_k(input int i);
    case (i)
      0: return 4; 1: return 4; 2: return 0; 3: return 3;
      4: return 8; 5: return 8; 6: return 3; default: return 0;
    endcase
  endfunction

  function automatic int cfg_t(input int i);
    case (i)
      0: return 8; 1: return 8; 2: return 0; 3: return 6;
      4: return 14; 5: return 0; 6: return 14; default: return 14;
    endcase
  endfunction

  function automatic int cfg_c(input int i);
    return (i == 1) ? 3 : 16;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       approx = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;

  logic [NI-1:0]       ir_all;
  logic [NI-1:0]       ov_all;
  logic [NI-1:0]       ao_all;
  logic [NI-1:0][15:0] z_all;
  logic [NI-1:0][15:0] cnt_all;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      logic [cfg_c(gi)-1:0] cnt_w;
      unsigned_nxn_approx_mul_pipe #(
        .N(8), .K(cfg_k(gi)), .T(cfg_t(gi)), .STAGES(2), .CNT_W(cfg_c(gi))
      ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_all[gi]),
        .x(x), .y(y), .approx(approx), .out_valid(ov_all[gi]),
        .out_ready(out_ready), .z(z_all[gi]), .approx_o(ao_all[gi]),
        .approx_cnt(cnt_w)
      );
      assign cnt_all[gi] = 16'(cnt_w);
    end
  endgenerate

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        ap;
    int          acc_cyc;
    bit          has_c;
    logic [15:0] c;
  } txn_t;

  txn_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   lat_chk = 1'b0;
  int   cnt_m [NI];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Product straight from the arithmetic definition: high rows exact, low rows
  // OR-compressed per column, columns below t dropped.
  function automatic logic [15:0] ref_mul(input logic [7:0] xa, input logic [7:0] yb,
                                          input logic ap, input int k, input int t);
    int unsigned xv, yv, hi, lo;
    xv = xa;
    yv = yb;
    if (!ap) return 16'(xv * yv);
    hi = (yv * (xv >> k)) << k;
    lo = 0;
    for (int c = t; c < 16; c++) begin
      for (int i = 0; i < k; i++) begin
        int j;
        j = c - i;
        if (j >= 0 && j < 8 && xv[i] && yv[j]) lo = lo | (32'd1 << c);
      end
    end
    return 16'(hi + lo);
  endfunction

  task automatic step(input logic iv, input logic [7:0] xi, input logic [7:0] yi,
                      input logic ai, input logic ordy, input bit hc, input logic [15:0] cv);
    txn_t t;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) check_eq($sformatf("cnt%0d", i), cnt_all[i], cnt_m[i]);
    in_valid  = iv;
    x         = xi;
    y         = yi;
    approx    = ai;
    out_ready = ordy;
    #1;
    check_eq("in_ready", ir_all[0], !ov_all[0] || ordy);
    if (sb.size() == 0) begin
      check_eq("ov_empty", ov_all[0], 0);
    end else begin
      t = sb[0];
      if (lat_chk && (cyc - t.acc_cyc >= 2)) check_eq("lat_valid", ov_all[0], 1);
      if (ov_all[0]) begin
        for (int i = 0; i < NI; i++) begin
          check_eq($sformatf("ov%0d", i), ov_all[i], 1);
          check_eq($sformatf("z%0d", i), z_all[i], ref_mul(t.x, t.y, t.ap, cfg_k(i), cfg_t(i)));
          check_eq($sformatf("ap%0d", i), ao_all[i], t.ap);
        end
        if (t.has_c) check_eq("z_const", z_all[0], t.c);
        if (ordy) begin
          if (lat_chk) check_eq("latency", cyc - t.acc_cyc, 2);
          $display("[TB] out x=%0d y=%0d ap=%0d z=%0d", t.x, t.y, t.ap, z_all[0]);
          void'(sb.pop_front());
        end
      end
    end
    if (iv && ir_all[0]) begin
      t.x = xi; t.y = yi; t.ap = ai; t.acc_cyc = cyc; t.has_c = hc; t.c = cv;
      sb.push_back(t);
      if (ai) begin
        for (int i = 0; i < NI; i++)
          if (cnt_m[i] < (1 << cfg_c(i)) - 1) cnt_m[i]++;
      end
    end
  endtask

  task automatic op(input logic [7:0] xi, input logic [7:0] yi, input logic ai,
                    input logic [15:0] cv);
    step(1'b1, xi, yi, ai, 1'b1, 1'b1, cv);
  endtask

  task automatic rnd_step(input int pv, input int pr);
    step(($urandom_range(99) < pv), 8'($urandom), 8'($urandom), 1'($urandom),
         ($urandom_range(99) < pr), 1'b0, 16'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && sb.size() != 0; n++) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0);
    check_eq("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst       = 1'b1;
    in_valid  = 1'b1;
    approx    = 1'b1;
    x         = 8'($urandom);
    y         = 8'($urandom);
    out_ready = 1'b0;
    #1;
    check_eq("rst_in_ready", ir_all[0], 1);
    @(negedge clk);
    cyc++;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("rst_ov%0d", i), ov_all[i], 0);
      check_eq($sformatf("rst_z%0d", i), z_all[i], 0);
      check_eq($sformatf("rst_ap%0d", i), ao_all[i], 0);
      check_eq($sformatf("rst_cnt%0d", i), cnt_all[i], 0);
      cnt_m[i] = 0;
    end
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < NI; i++) cnt_m[i] = 0;
    do_reset();

    // Directed exact and approximate products with known results.
    lat_chk = 1'b1;
    op(8'd255, 8'd255, 1'b0, 16'd65025);
    op(8'd0,   8'd200, 1'b0, 16'd0);
    op(8'd255, 8'd255, 1'b1, 16'd62992);
    op(8'h0F,  8'hFF,  1'b1, 16'd1792);
    op(8'h10,  8'd3,   1'b1, 16'd48);
    drain();

    // Ten back-to-back random operations, no stalls.
    for (int n = 0; n < 10; n++) rnd_step(100, 100);
    drain();
    lat_chk = 1'b0;

    // Hold the output for five cycles while inputs keep arriving.
    for (int n = 0; n < 3; n++) rnd_step(100, 100);
    for (int n = 0; n < 5; n++) rnd_step(100, 0);
    drain();

    // Counter saturation on the 3-bit instance, then reset mid-stream.
    do_reset();
    for (int n = 0; n < 12; n++) step(1'b1, 8'($urandom), 8'($urandom), (n < 9), 1'b1, 1'b0, 16'd0);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0);
    check_eq("cnt_sat", cnt_all[1], 7);
    check_eq("cnt_full", cnt_all[0], 9);
    do_reset();
    for (int n = 0; n < 4; n++) rnd_step(0, 100);

    // Random sweep with random input gaps and output stalls.
    for (int n = 0; n < 600; n++) rnd_step(70, 65);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
